// File: rtl/burst_collector.sv
// Burst collector: gathers up to DEPTH operands into a parallel bank with per-slot valid bits,
// holding the completed bank until the consumer acknowledges with take.
module burst_collector #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DEPTH        = 3,
  parameter int unsigned PARTIAL_MODE = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       putFlag,
  input  logic [WIDTH-1:0]           value,
  input  logic                       take,
  output logic [DEPTH*WIDTH-1:0]     regs,
  output logic [DEPTH-1:0]           valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       done,
  output logic                       overflow,
  output logic                       abort
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [DEPTH-1:0] Slot0 = DEPTH'(1);
  localparam logic [CW-1:0] CountFull = CW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StFill, StFull} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  slot_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [CW-1:0]     count_q, count_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  logic              abort_q, abort_d;
  logic              wr_en;
  logic [CW-1:0]     wr_idx;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    count_d    = count_q;
    done_d     = done_q;
    overflow_d = 1'b0;
    abort_d    = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = '0;
    unique case (state_q)
      StIdle: begin
        if (putFlag) begin
          wr_en   = 1'b1;
          valid_d = Slot0;
          count_d = CW'(1);
          if (DEPTH == 1) begin
            state_d = StFull;
            done_d  = 1'b1;
          end else begin
            state_d = StFill;
          end
        end
      end
      StFill: begin
        if (putFlag) begin
          wr_en   = 1'b1;
          wr_idx  = count_q;
          valid_d = valid_q | (Slot0 << count_q);
          count_d = count_q + CW'(1);
          if (count_d == CountFull) begin
            state_d = StFull;
            done_d  = 1'b1;
          end
        end else if (PARTIAL_MODE == 0) begin
          valid_d = '0;
          count_d = '0;
          abort_d = 1'b1;
          state_d = StIdle;
        end else begin
          // Short burst is kept as a partial bank.
          state_d = StFull;
          done_d  = 1'b1;
        end
      end
      StFull: begin
        if (take && putFlag) begin
          // Release and restart in one edge; the new operand lands in slot 0.
          wr_en   = 1'b1;
          valid_d = Slot0;
          count_d = CW'(1);
          if (DEPTH == 1) begin
            state_d = StFull;
            done_d  = 1'b1;
          end else begin
            state_d = StFill;
            done_d  = 1'b0;
          end
        end else if (take) begin
          valid_d = '0;
          count_d = '0;
          done_d  = 1'b0;
          state_d = StIdle;
        end else if (putFlag) begin
          overflow_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = '0;
        count_d = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      abort_q    <= abort_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_idx == CW'(i)) slot_q[i] <= value;
      end
    end
  end

  // Stored data survives release; valid masks it on the output.
  for (genvar g = 0; g < DEPTH; g++) begin : g_regs
    assign regs[g*WIDTH +: WIDTH] = valid_q[g] ? slot_q[g] : '0;
  end

  assign valid    = valid_q;
  assign count    = count_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign abort    = abort_q;

endmodule
